// File: rtl/trash_core.sv
// trash_core: parametrised 8-bit micro-core with a word-loaded program memory,
// register file, data memory and a single-cycle fetch/execute loop.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_LOAD | program words accepted via load_valid; start begins at pc 0
//   S_RUN  | one instruction from prog[pc] commits per clock
//   S_HALT | halted after a HALT instruction; start reruns from pc 0
module trash_core #(
  parameter int PROG_DEPTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int NUM_REGS   = 4,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [15:0]     load_data,
  input  logic            start,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            halted,
  output logic            running,
  output logic [PC_W-1:0] pc
);

  localparam int RI_W = $clog2(NUM_REGS);
  localparam int MA_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t          r_state;
  logic [15:0]     r_prog [PROG_DEPTH];
  logic [7:0]      r_regs [NUM_REGS];
  logic [7:0]      r_mem  [MEM_DEPTH];
  logic [PC_W-1:0] r_wr_ptr;

  logic [15:0]     w_instr;
  logic [3:0]      w_op;
  logic [3:0]      w_fn;
  logic [RI_W-1:0] w_ra;
  logic [RI_W-1:0] w_rb;
  logic [RI_W-1:0] w_rc;
  logic [MA_W-1:0] w_maddr;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic [7:0]      w_imm;
  logic [7:0]      w_x;
  logic [7:0]      w_y;
  logic [7:0]      w_alu;
  logic            w_prog_we;

  assign w_instr  = r_prog[pc];
  assign w_op     = w_instr[15:12];
  assign w_fn     = w_instr[11:8];
  assign w_ra     = w_instr[8 +: RI_W];
  assign w_rb     = w_instr[4 +: RI_W];
  assign w_rc     = w_instr[0 +: RI_W];
  assign w_maddr  = w_instr[8 +: MA_W];
  assign w_target = w_instr[8 +: PC_W];
  assign w_imm    = w_instr[7:0];
  assign w_x      = r_regs[w_rb];
  assign w_y      = r_regs[w_rc];
  assign w_pc_inc = pc + PC_W'(1);

  always_comb begin
    w_alu = w_x;
    case (w_fn)
      4'h0: w_alu = w_x + w_y;
      4'h1: w_alu = w_x - w_y;
      4'h2: w_alu = w_x * w_y;
      4'h3: w_alu = w_x & w_y;
      4'h4: w_alu = w_x | w_y;
      4'h5: w_alu = w_x ^ w_y;
      4'h6: w_alu = ~w_x;
      4'h7: w_alu = {w_x[6:0], 1'b0};
      4'h8: w_alu = {1'b0, w_x[7:1]};
      4'h9: w_alu = w_x + 8'd1;
      4'hA: w_alu = w_x - 8'd1;
      4'hB: w_alu = {7'd0, (w_x == w_y)};
      4'hC: w_alu = {7'd0, (w_x < w_y)};
      default: w_alu = w_x;
    endcase
  end

  // Program memory has no reset; a write coinciding with reset is dropped.
  assign w_prog_we = !reset && (r_state == S_LOAD) && load_valid;

  always_ff @(posedge clk) begin
    if (w_prog_we) r_prog[r_wr_ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      pc        <= '0;
      r_wr_ptr  <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      running   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (load_valid) r_wr_ptr <= r_wr_ptr + PC_W'(1);
          if (start) begin
            r_state <= S_RUN;
            pc      <= '0;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          pc <= w_pc_inc;
          case (w_op)
            4'h1: r_regs[w_ra] <= w_imm;
            4'h2: r_regs[w_rb] <= w_alu;
            4'h3: r_mem[w_maddr] <= w_x;
            4'h4: r_regs[w_rb] <= r_mem[w_maddr];
            4'h5: pc <= w_target;
            4'h6: if (w_x == w_y) pc <= w_target;
            4'h7: begin
              out_data  <= r_regs[w_ra];
              out_valid <= 1'b1;
            end
            4'h8: begin
              // pc stays on the HALT word
              pc      <= pc;
              r_state <= S_HALT;
              halted  <= 1'b1;
              running <= 1'b0;
            end
            default: ;
          endcase
        end
        S_HALT: begin
          if (start) begin
            r_state <= S_RUN;
            pc      <= '0;
            halted  <= 1'b0;
            running <= 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_trash_core.sv
// Scoreboard bench for trash_core: two instances (default and MEM_DEPTH=4/NUM_REGS=2)
// share stimulus; an instruction-level model predicts OUT values and pc/halt traces.
module tb_trash_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        start = 1'b0;

  logic [7:0] od0, od1;
  logic       ov0, ov1, h0, h1, rn0, rn1;
  logic [2:0] pc0, pc1;

  trash_core dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .start(start), .out_data(od0), .out_valid(ov0), .halted(h0), .running(rn0), .pc(pc0)
  );

  trash_core #(.PROG_DEPTH(8), .MEM_DEPTH(4), .NUM_REGS(2)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .start(start), .out_data(od1), .out_valid(ov1), .halted(h1), .running(rn1), .pc(pc1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int q0[$];
  int q1[$];

  logic [15:0] pb [8];
  logic [15:0] m_prog [8];
  int m_wp;
  int m_regs [2][16];
  int m_mem  [2][16];
  int tr_pc  [2][64];
  int tr_h   [2][64];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int fn, input int x, input int y);
    int r;
    case (fn)
      0: r = x + y;
      1: r = x - y;
      2: r = x * y;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = ~x;
      7: r = x * 2;
      8: r = x / 2;
      9: r = x + 1;
      10: r = x - 1;
      11: r = (x == y) ? 1 : 0;
      12: r = (x < y) ? 1 : 0;
      default: r = x;
    endcase
    return r & 255;
  endfunction

  // Executes up to ncyc instructions from pc 0, recording pc/halt after each one.
  task automatic model_run(input int cfg, input int ncyc);
    int nr, nm, pcv, halt, w, op, a, b, c, x, y, npc;
    nr = (cfg == 0) ? 4 : 2;
    nm = (cfg == 0) ? 16 : 4;
    pcv = 0;
    halt = 0;
    tr_pc[cfg][0] = 0;
    tr_h[cfg][0] = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (!halt) begin
        w  = int'(m_prog[pcv]);
        op = (w >> 12) & 15;
        a  = (w >> 8) & 15;
        b  = (w >> 4) & 15;
        c  = w & 15;
        x  = m_regs[cfg][b % nr];
        y  = m_regs[cfg][c % nr];
        npc = (pcv + 1) % 8;
        case (op)
          1: m_regs[cfg][a % nr] = w & 255;
          2: m_regs[cfg][b % nr] = alu_ref(a, x, y);
          3: m_mem[cfg][a % nm] = x;
          4: m_regs[cfg][b % nr] = m_mem[cfg][a % nm];
          5: npc = a % 8;
          6: if (x == y) npc = a % 8;
          7: if (cfg == 0) q0.push_back(m_regs[0][a % nr]); else q1.push_back(m_regs[1][a % nr]);
          8: begin npc = pcv; halt = 1; end
          default: ;
        endcase
        pcv = npc;
      end
      tr_pc[cfg][k] = pcv;
      tr_h[cfg][k] = halt;
    end
  endtask

  task automatic model_clear();
    for (int cfg = 0; cfg < 2; cfg++)
      for (int i = 0; i < 16; i++) begin
        m_regs[cfg][i] = 0;
        m_mem[cfg][i] = 0;
      end
    q0.delete();
    q1.delete();
    m_wp = 0;
  endtask

  task automatic do_reset(input bit noise);
    reset = 1'b1;
    if (noise) begin
      start = 1'b1;
      load_valid = 1'b1;
      load_data = 16'hFFFF;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
    model_clear();
    chk("rst_running0", int'(rn0), 0);
    chk("rst_halted0", int'(h0), 0);
    chk("rst_outvalid0", int'(ov0), 0);
    chk("rst_pc0", int'(pc0), 0);
    chk("rst_outdata0", int'(od0), 0);
    chk("rst_running1", int'(rn1), 0);
    chk("rst_outvalid1", int'(ov1), 0);
    chk("rst_pc1", int'(pc1), 0);
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data = pb[i];
      m_prog[m_wp] = pb[i];
      m_wp = (m_wp + 1) % 8;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic check_trace(input int k);
    chk("pc0", int'(pc0), tr_pc[0][k]);
    chk("halted0", int'(h0), tr_h[0][k]);
    chk("running0", int'(rn0), 1 - tr_h[0][k]);
    chk("pc1", int'(pc1), tr_pc[1][k]);
    chk("halted1", int'(h1), tr_h[1][k]);
  endtask

  task automatic start_run(input int ncyc, input bit noise, input bit with_load, input logic [15:0] lw);
    start = 1'b1;
    if (with_load) begin
      load_valid = 1'b1;
      load_data = lw;
      m_prog[m_wp] = lw;
      m_wp = (m_wp + 1) % 8;
    end
    model_run(0, ncyc);
    model_run(1, ncyc);
    @(posedge clk); #1;
    start = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check_trace(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (noise) begin
        load_valid = 1'($urandom_range(0, 1));
        load_data = 16'($urandom);
      end
      @(negedge clk);
      check_trace(k);
    end
    load_valid = 1'b0;
    #1;
    chk("outs_pending0", q0.size(), 0);
    chk("outs_pending1", q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  // Monitor: every OUT pulse must match the next predicted value.
  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out0_unexpected: got 0x%0h, expected no output", od0);
      end else chk("out0_data", int'(od0), q0.pop_front());
    end
    if (ov1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out1_unexpected: got 0x%0h, expected no output", od1);
      end else chk("out1_data", int'(od1), q1.pop_front());
    end
  end

  initial begin
    do_reset(0);

    pb = '{16'h1005, 16'h1103, 16'h2001, 16'h7000, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1003, 16'h1105, 16'h2101, 16'h7000, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1010, 16'h1110, 16'h2201, 16'h7000, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1003, 16'h1105, 16'h2C01, 16'h7000, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h12AA, 16'h3320, 16'h4330, 16'h7300, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1255, 16'h3720, 16'h4330, 16'h7300, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(8, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_words(8); start_run(10, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1107, 16'h1207, 16'h6512, 16'h7100, 16'h8000, 16'h1333, 16'h7300, 16'h8000};
    load_words(8); start_run(10, 0, 0, 16'h0); do_reset(0);

    pb = '{16'h1108, 16'h1207, 16'h6512, 16'h7100, 16'h8000, 16'h1333, 16'h7300, 16'h8000};
    load_words(8); start_run(10, 0, 0, 16'h0); do_reset(0);

    // HALT then start again with registers kept
    pb = '{16'h7000, 16'h1042, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_words(3); start_run(6, 0, 0, 16'h0); start_run(6, 1, 0, 16'h0); do_reset(0);

    pb = '{16'h135A, 16'h7100, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_words(3); start_run(6, 1, 0, 16'h0); do_reset(0);

    // word 0 loaded on the same edge as start
    start_run(6, 0, 1, 16'h7000); do_reset(0);

    pb = '{16'h1011, 16'h5100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_words(2); start_run(6, 0, 0, 16'h0); do_reset(0);

    // reset lands on the in-flight OUT, with start/load asserted alongside
    pb = '{16'h1005, 16'h1103, 16'h2001, 16'h7000, 16'h8000, 16'h0, 16'h0, 16'h0};
    load_words(5); start_run(3, 0, 0, 16'h0); do_reset(1);
    start_run(8, 0, 0, 16'h0); do_reset(0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 10));
        pb[i] = {op, 12'($urandom)};
      end
      load_words(8);
      start_run(24, 1, 0, 16'h0);
      do_reset(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trash_core.md
# trash_core

Parametrised 8-bit micro-core that succeeds the first fixed-size trash CPU. The program memory is loaded word-by-word over a simple valid interface. The core then executes one 16-bit instruction per clock from that memory, using a register file, a data memory, an 8-bit ALU, conditional jumps, a halt instruction and an output strobe. It sits behind the top-level pin wrapper, which maps `ui_in`/`uio_in` onto the load and control ports.

## Interface
- `PROG_DEPTH`, default 8: program words; power of 2, range 2..16; `PC_W = log2(PROG_DEPTH)`.
- `MEM_DEPTH`, default 16: data-memory bytes; power of 2, range 2..16.
- `NUM_REGS`, default 4: 8-bit registers; power of 2, range 2..16.
- `clk  in  1`: the only clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `load_valid  in  1`: write `load_data` to program memory (LOAD state only).
- `load_data  in  16`: instruction word to load.
- `start  in  1`: begin execution at pc 0 (LOAD or HALT state only).
- `out_data  out  8`: last value written by OUT; reset value 0x00.
- `out_valid  out  1`: one-cycle pulse per OUT; reset value 0.
- `halted  out  1`: high in HALT state; reset value 0.
- `running  out  1`: high in RUN state; reset value 0.
- `pc  out  PC_W`: current program counter; reset value 0.

## Operation
- FSM states: LOAD, RUN, HALT. Reset enters LOAD.
  - LOAD + `start` → RUN.
  - RUN + HALT instruction → HALT.
  - HALT + `start` → RUN.
- Reset clears: `pc`, load pointer `wr_ptr`, all registers, all data memory, and every output. Program memory is not reset and keeps its contents.
- LOAD state:
  - When `load_valid`=1: `prog[wr_ptr] <= load_data` and `wr_ptr` increments, wrapping modulo `PROG_DEPTH`.
  - When `start` is asserted: `pc <= 0`. `wr_ptr` is retained, not cleared.
- `load_valid` is ignored in RUN and HALT. `start` is ignored in RUN.
- Instruction fields: `op=[15:12]`, `A=[11:8]`, `B=[7:4]`, `C=[3:0]`, `imm=[7:0]`.
  - Register indices are truncated to `log2(NUM_REGS)` bits.
  - Memory addresses are truncated to `log2(MEM_DEPTH)` bits.
  - Jump targets are truncated to `PC_W` bits.
- Opcodes:
  - 0 NOP.
  - 1 LDI: `R[A] <= imm`.
  - 2 ALU: `R[B] <= f_A(R[B], R[C])`.
  - 3 ST: `MEM[A] <= R[B]`.
  - 4 LD: `R[B] <= MEM[A]`.
  - 5 JMP: `pc <= A`.
  - 6 JEQ: `pc <= A` if `R[B]==R[C]`.
  - 7 OUT: `out_data <= R[A]`, `out_valid <= 1`.
  - 8 HALT.
  - 9..F: execute as NOP.
- ALU functions `f_A(x,y)`, all unsigned 8-bit with results truncated to 8 bits:
  - 0 `x+y`; 1 `x-y`; 2 `x*y` (low 8 bits).
  - 3 `x&y`; 4 `x|y`; 5 `x^y`; 6 `~x`.
  - 7 `x<<1`; 8 `x>>1` (logical).
  - 9 `x+1`; A `x-1`.
  - B `x==y ? 1 : 0`; C `x<y ? 1 : 0`.
  - D..F `x` (pass-through).
- Program counter:
  - Non-jump and not-taken instructions: `pc <= pc+1`, wrapping modulo `PROG_DEPTH`.
  - HALT: `pc` holds at the HALT address.

## Timing
- Single-cycle execute: `prog[pc]` is read combinationally and its effects commit on the same rising edge.
- If `start` is sampled at edge N, `running`=1 and `pc`=0 after edge N, and `prog[0]` commits at edge N+1.
- A load at edge N of a word at address 0 together with `start` at edge N is allowed. That word is the one executed at edge N+1.
- OUT committed at edge N: `out_data`/`out_valid` valid after edge N; `out_valid` returns to 0 after edge N+1 unless the next instruction is also OUT. `out_data` holds its value until the next OUT.
- LD following ST to the same address in the next cycle returns the new value (memory is registered, with no bypass needed).
- JMP to its own address loops forever; `pc` is constant.
- HALT committed at edge N: `halted`=1 and `running`=0 after edge N.
- `reset` dominates everything, including a simultaneous `start`, `load_valid`, or an in-flight instruction. After the reset edge the state is LOAD with all outputs at their reset values.

## Test plan
- Add program: load 0x1005, 0x1103, 0x2001, 0x7000, 0x8000; pulse `start` → exactly one `out_valid` pulse with `out_data`=0x08, then `halted`=1 with `pc`=4.
- ALU wrap: R0=3, R1=5, ALU op 1 (0x2101) → R0=0xFE after OUT. R0=0x10, R1=0x10, op 2 → 0x00. Op C (3<5) → 0x01.
- Memory: 0x12AA, 0x3320, 0x4330, 0x7300 → `out_data`=0xAA. With `MEM_DEPTH`=4, ST to address 7 then LD from address 3 returns the same byte.
- Branches and wrap (`PROG_DEPTH`=8):
  - Program of eight NOPs: `pc` sequence 0..7,0.
  - JEQ with R1==R2 jumps to A; with R1!=R2, `pc` advances by 1.
  - HALT then `start` reruns from `pc`=0 with registers retained.
- Reset mid-run after 3 instructions → next cycle: `running`=0, `pc`=0, registers read 0, `out_valid`=0. A new `start` reruns the retained program with identical output.
- `NUM_REGS`=2: LDI to register 3 then OUT register 1 → same value (index aliasing). `load_valid` pulses during RUN do not alter program output.
